// File: rtl/spi_main.sv
// ============================================================================
// Module   : spi_main
// Brief    : SPI mode-0 main controller, MSB first, optional held chip-select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_main #(
    parameter int WORD_BITS = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 neg_enable,
    output logic                 sck,
    output logic                 out_bit,
    input  logic                 in_bit,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [WORD_BITS-1:0] tx_word,
    input  logic                 hold_cs,
    output logic                 rx_valid,
    output logic [WORD_BITS-1:0] rx_word
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TRAIL = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t               r_state, w_state;
    logic [c_DIV_W-1:0]   r_div, w_div;
    logic [c_CNT_W-1:0]   r_bit_cnt, w_bit_cnt;
    logic [WORD_BITS-1:0] r_tx_sh, w_tx_sh;
    logic [WORD_BITS-1:0] r_rx_sh, w_rx_sh;
    logic [WORD_BITS-1:0] r_rx_word, w_rx_word;
    logic                 r_hold_q, w_hold_q;
    logic                 r_neg_enable, w_neg_enable;
    logic                 r_sck, w_sck;
    logic                 r_out_bit, w_out_bit;
    logic                 r_rx_valid, w_rx_valid;
    logic                 w_tick;
    logic                 w_ready;
    logic                 w_accept;
    logic [WORD_BITS-1:0] w_rx_next;

    always_comb begin
        w_state      = r_state;
        w_div        = '0;
        w_bit_cnt    = r_bit_cnt;
        w_tx_sh      = r_tx_sh;
        w_rx_sh      = r_rx_sh;
        w_rx_word    = r_rx_word;
        w_hold_q     = r_hold_q;
        w_neg_enable = r_neg_enable;
        w_sck        = r_sck;
        w_out_bit    = r_out_bit;
        w_rx_valid   = 1'b0;
        w_tick       = (r_div == c_DIV_LAST);
        w_ready      = (r_state == S_IDLE) || (r_state == S_HOLD);
        w_accept     = tx_valid && w_ready;
        w_rx_next    = {r_rx_sh[WORD_BITS-2:0], in_bit};

        if ((r_state inside {S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP}) && !w_tick) begin
            w_div = r_div + 1'b1;
        end

        // Accept is shared by IDLE and HOLD; from HOLD the frame continues with CS low.
        if (w_accept) begin
            w_tx_sh      = tx_word;
            w_hold_q     = hold_cs;
            w_bit_cnt    = '0;
            w_neg_enable = 1'b0;
            w_out_bit    = tx_word[WORD_BITS-1];
            w_state      = S_LEAD;
        end else begin
            case (r_state)
                S_LEAD, S_LOW: begin
                    if (w_tick) begin
                        w_sck   = 1'b1;
                        w_state = S_HIGH;
                    end
                end
                S_HIGH: begin
                    // Sampling at the end of the high phase absorbs the secondary's sck sync delay.
                    if (w_tick) begin
                        w_sck   = 1'b0;
                        w_rx_sh = w_rx_next;
                        if (r_bit_cnt != c_BIT_LAST) begin
                            w_out_bit = r_tx_sh[WORD_BITS-2];
                            w_tx_sh   = r_tx_sh << 1;
                            w_bit_cnt = r_bit_cnt + 1'b1;
                            w_state   = S_LOW;
                        end else begin
                            w_rx_word  = w_rx_next;
                            w_rx_valid = 1'b1;
                            w_state    = S_TRAIL;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        if (r_hold_q) begin
                            w_state = S_HOLD;
                        end else begin
                            w_neg_enable = 1'b1;
                            w_out_bit    = 1'b0;
                            w_state      = S_GAP;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold_cs) begin
                        w_neg_enable = 1'b1;
                        w_out_bit    = 1'b0;
                        w_state      = S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        w_state = S_IDLE;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit_cnt    <= '0;
            r_tx_sh      <= '0;
            r_rx_sh      <= '0;
            r_rx_word    <= '0;
            r_hold_q     <= 1'b0;
            r_neg_enable <= 1'b1;
            r_sck        <= 1'b0;
            r_out_bit    <= 1'b0;
            r_rx_valid   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_div        <= w_div;
            r_bit_cnt    <= w_bit_cnt;
            r_tx_sh      <= w_tx_sh;
            r_rx_sh      <= w_rx_sh;
            r_rx_word    <= w_rx_word;
            r_hold_q     <= w_hold_q;
            r_neg_enable <= w_neg_enable;
            r_sck        <= w_sck;
            r_out_bit    <= w_out_bit;
            r_rx_valid   <= w_rx_valid;
        end
    end

    assign tx_ready   = !rst && w_ready;
    assign neg_enable = r_neg_enable;
    assign sck        = r_sck;
    assign out_bit    = r_out_bit;
    assign rx_valid   = r_rx_valid;
    assign rx_word    = r_rx_word;

endmodule

`default_nettype wire

// File: tb/tb_spi_main.sv
// ============================================================================
// Module   : tb_spi_main
// Brief    : Self-checking bench for spi_main with a wire-level secondary model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_main;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int W2 = 16;
    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         neg_enable, sck, out_bit, in_bit, tx_valid, tx_ready, hold_cs, rx_valid;
    logic [W-1:0] tx_word, rx_word;

    logic          b_ne, b_sck, b_out, b_in, b_txv, b_txr, b_hold, b_rxv;
    logic [W2-1:0] b_txw, b_rxw, b_sec;

    spi_main #(.WORD_BITS(W), .CLK_DIV(D)) u_dut (
        .clk(clk), .rst(rst), .neg_enable(neg_enable), .sck(sck), .out_bit(out_bit),
        .in_bit(in_bit), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_word(tx_word),
        .hold_cs(hold_cs), .rx_valid(rx_valid), .rx_word(rx_word)
    );

    spi_main #(.WORD_BITS(W2), .CLK_DIV(D2)) u_dut16 (
        .clk(clk), .rst(rst), .neg_enable(b_ne), .sck(b_sck), .out_bit(b_out),
        .in_bit(b_in), .tx_valid(b_txv), .tx_ready(b_txr), .tx_word(b_txw),
        .hold_cs(b_hold), .rx_valid(b_rxv), .rx_word(b_rxw)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: each accepted word must reappear on MOSI, and the reply must come back.
    logic [W-1:0] exp_tx[$];
    logic [W-1:0] exp_rx[$];
    int           acc_q[$];
    logic [W-1:0] sec_q[$];

    logic [W-1:0] sec_sh   = '0;
    int           sec_cnt  = 0;
    logic [W-1:0] mosi_sh  = '0;
    int           mosi_cnt = 0;
    logic [31:0]  frame_sh = '0;
    logic         prev_ne  = 1'b1;
    logic         prev_sck = 1'b0;
    int           ne_rise  = 0;
    int           rxv_cnt  = 0;
    int           acc_cnt  = 0;
    int           viol     = 0;
    logic         ob_seen  = 1'b0;

    assign in_bit = sec_sh[W-1];
    assign b_in   = b_sec[W2-1];

    always @(posedge clk) begin
        if (tx_valid && tx_ready) acc_cnt++;
    end

    always @(negedge clk) begin
        if (neg_enable === 1'b1) begin
            sec_cnt  = 0;
            mosi_cnt = 0;
        end
        if (prev_ne && !neg_enable) frame_sh = '0;
        if (!prev_ne && neg_enable) ne_rise++;
        if (sck && neg_enable) viol++;
        if (sck && prev_sck && (neg_enable != prev_ne)) viol++;
        if (sck && !prev_sck) begin
            mosi_sh  = {mosi_sh[W-2:0], out_bit};
            mosi_cnt++;
            frame_sh = {frame_sh[30:0], out_bit};
            if (sec_cnt == 0) sec_sh = (sec_q.size() > 0) ? sec_q.pop_front() : '0;
        end
        if (!sck && prev_sck) begin
            sec_sh  = sec_sh << 1;
            sec_cnt = (sec_cnt == W - 1) ? 0 : sec_cnt + 1;
        end
        if (out_bit === 1'b1) ob_seen = 1'b1;
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            if (exp_rx.size() == 0) begin
                check("rx_spurious", 32'd1, 32'd0);
            end else begin
                check("rx_word", rx_word, exp_rx.pop_front());
                check("mosi_word", mosi_sh, exp_tx.pop_front());
                check("mosi_bits", mosi_cnt, W);
                check("rx_latency", cyc - acc_q.pop_front(), 1 + 2 * W * D);
            end
            mosi_cnt = 0;
        end
        prev_ne  = neg_enable;
        prev_sck = sck;
    end

    task automatic send(input logic [W-1:0] w, input logic h, input logic [W-1:0] rep,
                        output int a);
        int t;
        @(negedge clk);
        tx_valid = 1'b1; tx_word = w; hold_cs = h; t = 0;
        while (!tx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        a = cyc;
        if (t >= 1000) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_tx.push_back(w);
            exp_rx.push_back(rep);
            acc_q.push_back(cyc);
            sec_q.push_back(rep);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_word  = W'($urandom);
    endtask

    task automatic wait_cs_high(output int c);
        int t = 0;
        while (!neg_enable && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("cs_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic wait_ready(output int c);
        int t = 0;
        while (!tx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("ready_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(tx_ready && neg_enable) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run16(input logic [W2-1:0] w, input logic [W2-1:0] rep);
        int a, t, last_rise;
        logic [W2-1:0] mo;
        logic ps;
        @(negedge clk);
        b_txw = w; b_txv = 1'b1; b_hold = 1'b0; b_sec = rep; t = 0;
        while (!b_txr && t < 100) begin
            @(negedge clk);
            t++;
        end
        a = cyc;
        @(negedge clk);
        b_txv = 1'b0;
        mo = '0; last_rise = -1; ps = b_sck; t = 0;
        while (!b_rxv && t < 300) begin
            if (b_sck && !ps) begin
                mo = {mo[W2-2:0], b_out};
                if (last_rise >= 0) check("sck_period16", cyc - last_rise, 2 * D2);
                last_rise = cyc;
            end
            if (!b_sck && ps) b_sec = b_sec << 1;
            ps = b_sck;
            @(negedge clk);
            t++;
        end
        check("rx_latency16", cyc - a, 1 + 2 * W2 * D2);
        check("rx_word16", b_rxw, rep);
        check("mosi16", mo, w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, c, rxv0, acc0;
        logic [W-1:0] w, r;
        rst = 1'b1; tx_valid = 1'b0; tx_word = '0; hold_cs = 1'b0;
        b_txv = 1'b0; b_txw = '0; b_hold = 1'b0; b_sec = '0;
        repeat (3) @(negedge clk);
        check("rst_ne", neg_enable, 1);
        check("rst_sck", sck, 0);
        check("rst_out", out_bit, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxw", rx_word, 0);
        check("rst_ready", tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        // Single word with fixed timing landmarks.
        send(8'hA5, 1'b0, 8'h3C, a);
        check("cs_fall", neg_enable, 0);
        check("lead_sck", sck, 0);
        check("lead_out", out_bit, 1);
        wait_cs_high(c);
        check("cs_rise_cycle", c - a, 69);
        wait_ready(c);
        check("ready_cycle", c - a, 73);

        // Held two-word frame.
        ne_rise = 0; rxv0 = rxv_cnt;
        send(8'h01, 1'b1, W'($urandom), a);
        send(8'h80, 1'b0, W'($urandom), a);
        wait_idle();
        check("held_cs_rises", ne_rise, 1);
        check("held_rx_pulses", rxv_cnt - rxv0, 2);
        check("held_frame", frame_sh[15:0], 16'h0180);

        // Release from HOLD.
        send(W'($urandom), 1'b1, W'($urandom), a);
        wait_ready(c);
        check("hold_cs_low", neg_enable, 0);
        hold_cs = 1'b0;
        @(negedge clk);
        check("hold_release", neg_enable, 1);
        for (int i = 0; i < D; i++) begin
            check("gap_ready", tx_ready, 0);
            @(negedge clk);
        end
        check("gap_done_ready", tx_ready, 1);

        // Offer while busy must be ignored.
        ob_seen = 1'b0; acc0 = acc_cnt;
        send(8'h00, 1'b0, W'($urandom), a);
        while (cyc < a + 20) @(negedge clk);
        tx_valid = 1'b1; tx_word = 8'hFF; hold_cs = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; hold_cs = 1'b0;
        wait_idle();
        check("busy_accepts", acc_cnt - acc0, 1);
        check("busy_out_bit", ob_seen, 0);

        // Reset in the middle of a word.
        rxv0 = rxv_cnt;
        send(W'($urandom), 1'b0, W'($urandom), a);
        while (cyc < a + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ne", neg_enable, 1);
        check("midrst_sck", sck, 0);
        check("midrst_out", out_bit, 0);
        @(negedge clk);
        exp_tx.delete(); exp_rx.delete(); acc_q.delete(); sec_q.delete();
        repeat (80) @(negedge clk);
        check("midrst_no_rxv", rxv_cnt - rxv0, 0);
        send(W'($urandom), 1'b0, W'($urandom), a);
        wait_idle();

        // Randomized frames with random hold and idle gaps.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = W'($urandom);
            r = W'($urandom);
            send(w, (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0, r, a);
        end
        wait_idle();
        check("pending_words", exp_rx.size(), 0);

        // Minimum divider, wide word.
        run16(16'hBEEF, W2'($urandom));
        run16(W2'($urandom), W2'($urandom));

        check("wire_invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_main.md
Name: spi_main

Overview:
SPI main (initiator) controller. It drives the wire side that a SpiSecondary receives: neg_enable, sck, and the main-out/secondary-in bit. It also samples the secondary's return bit. Words come from a bus-side valid/ready interface and are shifted MSB first in SPI mode 0 (data changes on falling sck, is sampled on rising sck). Chip-select can be held low across consecutive words for multi-word frames.

Parameters:
WORD_BITS, 8, bits per SPI word; must be >= 2.
CLK_DIV, 4, clk cycles per sck half-period; must be >= 2, and >= 4 when the secondary syncs sck through a 2-FF synchronizer.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
neg_enable  out  1  chip select, active low.
sck  out  1  SPI clock, idles low.
out_bit  out  1  main-out/secondary-in data.
in_bit  in  1  main-in/secondary-out data.
tx_valid  in  1  bus has a word to send.
tx_ready  out  1  block accepts a word this cycle.
tx_word  in  WORD_BITS  word to send; MSB goes out first.
hold_cs  in  1  keep neg_enable low after the current word; sampled at accept.
rx_valid  out  1  one-cycle pulse: rx_word holds the word just received.
rx_word  out  WORD_BITS  received word, MSB first on the wire.

Behaviour:
- All outputs are registered except tx_ready = !rst & (state==IDLE | state==HOLD).
- Reset values: neg_enable=1, sck=0, out_bit=0, rx_valid=0, rx_word=0; state=IDLE; counters=0.
- States: IDLE, LEAD, HIGH, LOW, TRAIL, HOLD, GAP. A divider counts 0..CLK_DIV-1 in every timed state; "tick" means the count is at CLK_DIV-1.
- Accept happens when tx_valid & tx_ready, called cycle 0. On accept:
  - latch tx_word into the tx shift register and hold_cs into hold_q;
  - bit_cnt <= 0;
  - next cycle: neg_enable=0, out_bit=tx_word[WORD_BITS-1], state LEAD.
- LEAD: on tick, sck<=1 and go to HIGH.
- HIGH: on tick, sck<=1->0 and sample in_bit into the rx shift register (shift left, new bit at LSB). The sample is taken at the end of the high phase to absorb the secondary's sync latency.
  - If bit_cnt < WORD_BITS-1: out_bit <= next tx bit, bit_cnt++, go to LOW.
  - Else: rx_word <= the completed shift value, rx_valid<=1 for exactly that one cycle, go to TRAIL.
- LOW: on tick, sck<=1 and go to HIGH.
- Cycle-level check for WORD_BITS=8, CLK_DIV=4:
  - neg_enable falls at cycle 1;
  - sck rises at 5+8k and falls at 9+8k for k=0..7;
  - last fall and rx_valid are at cycle 65 (general formula: 1+2*WORD_BITS*CLK_DIV).
- TRAIL: neg_enable stays low. On tick:
  - if hold_q, go to HOLD;
  - else neg_enable<=1, out_bit<=0, go to GAP.
- HOLD: neg_enable stays low, sck low, tx_ready=1.
  - Accept starts the next word directly in LEAD; neg_enable never pulses high.
  - If there is no accept and hold_cs=0: neg_enable<=1, out_bit<=0, go to GAP.
- GAP: neg_enable high for CLK_DIV cycles (minimum deselect time), then IDLE.
- tx_valid while tx_ready=0 is ignored. tx_word and hold_cs may change freely after accept.
- Reset mid-operation: the next cycle gives reset values and IDLE. The partial word is discarded; no rx_valid.
- Width rules:
  - divider is clog2(CLK_DIV) bits;
  - bit_cnt is clog2(WORD_BITS) bits and never wraps, because the terminal compare is against WORD_BITS-1;
  - shift registers are exactly WORD_BITS bits.
- sck is never high outside HIGH. neg_enable never changes while sck=1.

Test Plan:
1. Single word: CLK_DIV=4, tx_word=8'hA5, hold_cs=0; loopback model drives in_bit from an 8'h3C shift register. Required: out_bit sampled at sck rises reads 1,0,1,0,0,1,0,1; rx_valid exactly once at cycle 65 with rx_word=8'h3C; neg_enable high at cycle 69; tx_ready high at cycle 73.
2. Held frame: send 8'h01 with hold_cs=1, then 8'h80 with hold_cs=0 offered as soon as tx_ready rises. Required: neg_enable stays low continuously across both words; two rx_valid pulses; a SpiSecondary attached (WORD_BITS=8) shifts in 16'h0180.
3. HOLD release: hold_cs=1 word, then tx_valid=0 and hold_cs=0 in HOLD. Required: neg_enable rises on the cycle after that HOLD cycle, followed by a CLK_DIV-cycle GAP with tx_ready=0.
4. Busy ignore: pulse tx_valid with 8'hFF during cycle 20 of a transfer of 8'h00. Required: out_bit stays 0 for the whole word; exactly one accept occurs.
5. Reset mid-word: assert rst for one cycle at cycle 30. Required: cycle 31 shows neg_enable=1, sck=0, out_bit=0; no rx_valid; a new transfer afterwards is correct.
6. Minimum divider: CLK_DIV=2, WORD_BITS=16, tx_word=16'hBEEF. Required: rx_valid at cycle 65; sck period is 4 clk cycles; received data matches the looped-back value.
